// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory that answers one load/store at a time.
// A request is accepted in IDLE, waits LAT cycles in WAIT, then the array is
// accessed on the edge that enters RESP, where the response is held until taken.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid / req_ready  request handshake (ready only in IDLE)
//   req_we                 1 = store, 0 = load
//   req_size               00 byte, 01 half, 10 word, 11 illegal
//   req_addr, req_wdata    byte address, right-justified store data
//   resp_valid/resp_ready  response handshake
//   resp_rdata, resp_err   right-justified zero-filled load data, reject flag
module dmem_responder #(
  parameter int          AW   = 12,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        cap_we;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [0:(1<<AW)-1];

  // Rejection rules: illegal size, misalignment, or outside the window.
  // The range test uses the full 32-bit difference so addresses below BASE
  // wrap to huge offsets and are caught as well.
  function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr,
                                     input logic [31:0] diff);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if (({1'b0, diff} >> 2) >= (33'd1 << AW)) bad = 1'b1;
    if (addr < BASE) bad = 1'b1;
    return bad;
  endfunction

  // Byte-lane enables for a given size and low address bits.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << {off[1], 1'b0};
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Right-justified mask of the significant bits for a given size.
  function automatic logic [31:0] size_bits(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      2'b00:   m = 32'h0000_00FF;
      2'b01:   m = 32'h0000_FFFF;
      2'b10:   m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  logic          accept;
  logic          access;
  logic          acc_we;
  logic [1:0]    acc_size;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [31:0]   acc_diff;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wshift;
  logic [31:0]   resp_data_nxt;

  assign accept = req_valid && req_ready;

  // With LAT==0 the access happens on the accepting edge, so the operands come
  // straight from the request ports; otherwise from the captured copy.
  always_comb begin
    acc_we        = 1'b0;
    acc_size      = 2'b00;
    acc_addr      = 32'h0000_0000;
    acc_wdata     = 32'h0000_0000;
    access        = 1'b0;
    resp_data_nxt = 32'h0000_0000;
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      access    = rst_n && accept && (LAT == 0);
    end else begin
      acc_we    = cap_we;
      acc_size  = cap_size;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      access    = rst_n && (state == WAIT) && (cnt == 3'd0);
    end
    acc_diff   = acc_addr - BASE;
    acc_idx    = acc_diff[AW+1:2];
    acc_err    = req_error(acc_size, acc_addr, acc_diff);
    acc_be     = lane_mask(acc_size, acc_addr[1:0]);
    acc_wshift = acc_wdata << {acc_addr[1:0], 3'b000};
    if (!acc_err && !acc_we) begin
      resp_data_nxt = (mem[acc_idx] >> {acc_addr[1:0], 3'b000}) & size_bits(acc_size);
    end else begin
      resp_data_nxt = 32'h0000_0000;
    end
  end

  // Array write port: only selected lanes of a legal store, never cleared by reset.
  always_ff @(posedge clk) begin
    if (access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wshift[8*i +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      cap_we     <= 1'b0;
      cap_size   <= 2'b00;
      cap_addr   <= 32'h0000_0000;
      cap_wdata  <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_we    <= req_we;
            cap_size  <= req_size;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (LAT == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= acc_err;
              resp_rdata <= resp_data_nxt;
            end else begin
              state <= WAIT;
              cnt   <= 3'(LAT - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= resp_data_nxt;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0000_0000;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= 3'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LAT = 1, 0 and 3.
module tb_dmem_responder;

  logic             clk = 1'b0;
  logic [2:0]       rst_n;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0]       req_we;
  logic [2:0][1:0]  req_size;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0]       resp_valid;
  logic [2:0]       resp_ready;
  logic [2:0][31:0] resp_rdata;
  logic [2:0]       resp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .AW  (12),
      .BASE(32'h0000_0000),
      .LAT ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  // Issue one request on instance d, take the response immediately, and report
  // data, error and acceptance-to-resp_valid latency in cycles.
  task automatic do_req(input int d, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_addr[d] = addr; req_wdata[d] = wdata; resp_ready[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    rdata = resp_rdata[d];
    err   = resp_err[d];
    checks++;
    if (resp_valid[d] !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout dut%0d addr=%h: resp_valid=%b required 1", d, addr, resp_valid[d]);
    end
  endtask

  task automatic test_reset;
    rst_n = 3'b000; req_valid = 3'b001; req_we = 3'b111; req_size = '0;
    req_addr = '0; req_wdata = '1; resp_ready = 3'b111;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({resp_valid[d], resp_err[d], resp_rdata[d], req_ready[d]} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid=%b err=%b rdata=%h ready=%b required 0 0 0 1",
                 d, resp_valid[d], resp_err[d], resp_rdata[d], req_ready[d]);
      end
    end
    req_valid = 3'b000;
    rst_n = 3'b111;
    @(negedge clk);
    checks++;
    if (resp_valid !== 3'b000 || req_ready !== 3'b111) begin
      errors++;
      $display("FAIL after_reset: resp_valid=%b req_ready=%b required 000 111", resp_valid, req_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] r; logic e; int lat;
    do_req(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, r, e, lat);
    checks++;
    if ({r, e} !== {32'h0, 1'b0} || lat != 2) begin
      errors++; $display("FAIL store_word: rdata=%h err=%b lat=%0d required 0 0 2", r, e, lat);
    end
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'hDEADBEEF, 1'b0} || lat != 2) begin
      errors++; $display("FAIL load_word: rdata=%h err=%b lat=%0d required deadbeef 0 2", r, e, lat);
    end
  endtask

  task automatic test_lanes;
    logic [31:0] r; logic e; int lat;
    do_req(0, 1'b1, 2'b00, 32'h13, 32'hFFFFFF5A, r, e, lat);
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'h5AADBEEF, 1'b0}) begin
      errors++; $display("FAIL byte_store: rdata=%h err=%b required 5aadbeef 0", r, e);
    end
    do_req(0, 1'b0, 2'b01, 32'h12, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'h00005AAD, 1'b0}) begin
      errors++; $display("FAIL load_half: rdata=%h err=%b required 00005aad 0", r, e);
    end
    do_req(0, 1'b0, 2'b00, 32'h11, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'h000000BE, 1'b0}) begin
      errors++; $display("FAIL load_byte: rdata=%h err=%b required 000000be 0", r, e);
    end
    do_req(0, 1'b1, 2'b01, 32'h10, 32'hAAAA1234, r, e, lat);
    do_req(0, 1'b0, 2'b10, 32'h10, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'h5AAD1234, 1'b0}) begin
      errors++; $display("FAIL half_store: rdata=%h err=%b required 5aad1234 0", r, e);
    end
  endtask

  task automatic test_errors;
    logic [31:0] r; logic e; int lat;
    logic [31:0] ea [5];
    logic        ew [5];
    logic [1:0]  es [5];
    ea = '{32'h11, 32'h4002, 32'h4000, 32'h0, 32'h0};
    ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    es = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    do_req(0, 1'b1, 2'b10, 32'h0, 32'h11223344, r, e, lat);
    for (int i = 0; i < 5; i++) begin
      do_req(0, ew[i], es[i], ea[i], 32'hBAD0BAD0, r, e, lat);
      checks++;
      if ({r, e} !== {32'h0, 1'b1} || lat != 2) begin
        errors++;
        $display("FAIL error_req%0d addr=%h: rdata=%h err=%b lat=%0d required 0 1 2", i, ea[i], r, e, lat);
      end
    end
    do_req(0, 1'b0, 2'b10, 32'h0, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'h11223344, 1'b0}) begin
      errors++; $display("FAIL mem_unchanged: rdata=%h err=%b required 11223344 0", r, e);
    end
    do_req(0, 1'b1, 2'b10, 32'h3FFC, 32'hA5A5C3C3, r, e, lat);
    do_req(0, 1'b0, 2'b10, 32'h3FFC, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'hA5A5C3C3, 1'b0}) begin
      errors++; $display("FAIL last_word: rdata=%h err=%b required a5a5c3c3 0", r, e);
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'b10; req_addr[0] = 32'h10;
    resp_ready[0] = 1'b0;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0]} !== {1'b1, 32'h5AAD1234, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold%0d: valid=%b rdata=%h err=%b ready=%b required 1 5aad1234 0 0",
                 i, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0]);
      end
      @(negedge clk);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({resp_valid[0], req_ready[0]} !== 2'b01) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b required 0 1", resp_valid[0], req_ready[0]);
    end
  endtask

  task automatic test_latency;
    logic [31:0] r; logic e; int lat;
    do_req(1, 1'b1, 2'b10, 32'h40, 32'h0BADF00D, r, e, lat);
    do_req(1, 1'b0, 2'b10, 32'h40, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'h0BADF00D, 1'b0} || lat != 1) begin
      errors++; $display("FAIL lat0: rdata=%h err=%b lat=%0d required 0badf00d 0 1", r, e, lat);
    end
    do_req(2, 1'b1, 2'b10, 32'h40, 32'h600DCAFE, r, e, lat);
    do_req(2, 1'b0, 2'b10, 32'h40, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'h600DCAFE, 1'b0} || lat != 4) begin
      errors++; $display("FAIL lat3: rdata=%h err=%b lat=%0d required 600dcafe 0 4", r, e, lat);
    end
  endtask

  task automatic test_back_to_back(input int d, input int period);
    int acc[$];
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = 1'b0; req_size[d] = 2'b10; req_addr[d] = 32'h0;
    resp_ready[d] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (req_ready[d] === 1'b1) acc.push_back(c);
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (acc.size() < 3) begin
      errors++; $display("FAIL b2b_dut%0d: accepts=%0d required >=3", d, acc.size());
    end else if (acc[1] - acc[0] != period || acc[2] - acc[1] != period) begin
      errors++;
      $display("FAIL b2b_dut%0d: spacing=%0d,%0d required %0d", d, acc[1] - acc[0], acc[2] - acc[1], period);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] r; logic e; int lat; int n;
    do_req(2, 1'b1, 2'b10, 32'h20, 32'hCAFEF00D, r, e, lat);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'b10;
    req_addr[2] = 32'h20; req_wdata[2] = 32'h12345678;
    n = 0;
    while (req_ready[2] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    // Now in WAIT; a request presented during reset must be ignored too.
    rst_n[2] = 1'b0;
    req_wdata[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid[2] !== 1'b0) begin
        errors++; $display("FAIL rst_valid%0d: resp_valid=%b required 0", i, resp_valid[2]);
      end
    end
    req_valid[2] = 1'b0;
    rst_n[2] = 1'b1;
    checks++;
    if (req_ready[2] !== 1'b1) begin
      errors++; $display("FAIL rst_ready: req_ready=%b required 1", req_ready[2]);
    end
    do_req(2, 1'b0, 2'b10, 32'h20, 32'h0, r, e, lat);
    checks++;
    if ({r, e} !== {32'hCAFEF00D, 1'b0}) begin
      errors++; $display("FAIL rst_discard: rdata=%h err=%b required cafef00d 0", r, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_errors();
    test_backpressure();
    test_latency();
    test_back_to_back(1, 2);
    test_back_to_back(2, 5);
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
